// File: rtl/ringuart.sv
// ringuart: UART client for one ringnode, using the same toggle handshake
// as the SPI client.
//
// Inbound serial bytes on RXD are assembled into WIDTH-bit words (most
// significant byte first) and offered to the node through rxdata and the
// mosivalid/mosiack toggle pair. Words posted by the node through txdata and
// the misovalid/misoack toggle pair are serialised onto TXD. The node
// double-synchronises both toggle handshakes, so none is added here.
//
// Parameters
//   WIDTH    ring word width, a multiple of 8 (NB = WIDTH/8 bytes per word)
//   CLKDIV   clk cycles per UART bit, >= 4
//   TIMEOUT  idle bit-times after which a partial inbound word is discarded
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   RXD          serial input, idle high, asynchronous to clk
//   TXD          serial output, idle high
//   rxdata       assembled inbound word for the node
//   mosivalid    toggles when rxdata holds a new word
//   mosiack      node toggles it to match mosivalid once rxdata is taken
//   txdata       outbound word from the node
//   misovalid    node toggles it when txdata is valid
//   misoack      toggled once txdata has been latched
//   overrun      sticky: an inbound word was dropped because the node was busy
//   framing_err  sticky: a stop bit was sampled low
module ringuart #(
    parameter int WIDTH   = 16,
    parameter int CLKDIV  = 104,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RXD,
    output logic             TXD,
    output logic [WIDTH-1:0] rxdata,
    output logic             mosivalid,
    input  logic             mosiack,
    input  logic [WIDTH-1:0] txdata,
    input  logic             misovalid,
    output logic             misoack,
    output logic             overrun,
    output logic             framing_err
);

    localparam int NB = WIDTH / 8;
    localparam int TW = $clog2(CLKDIV);
    localparam int OW = $clog2(TIMEOUT * CLKDIV);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKDIV / 2 - 1);
    localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT * CLKDIV - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_STOP   = 3'd3;
    localparam logic [2:0] RX_WAITHI = 3'd4;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    // ---------------- receive side ----------------
    logic             rx_meta;
    logic             rxs;
    logic             rxs_d;
    logic [2:0]       rx_state;
    logic [TW-1:0]    rx_timer;
    logic [2:0]       rx_bitcnt;
    logic [BW-1:0]    rx_bytecnt;
    logic [OW-1:0]    rx_tocnt;
    logic             word_done;
    logic [7:0]       rx_sh;
    logic [WIDTH-1:0] rx_word;

    logic start_edge;
    logic rx_bit_smp;
    logic rx_byte_ok;

    assign start_edge = rxs_d & ~rxs;
    assign rx_bit_smp = (rx_state == RX_DATA) && (rx_timer == '0);
    assign rx_byte_ok = (rx_state == RX_STOP) && (rx_timer == '0) && rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            rxs_d       <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_timer    <= '0;
            rx_bitcnt   <= '0;
            rx_bytecnt  <= '0;
            rx_tocnt    <= '0;
            word_done   <= 1'b0;
            rxdata      <= '0;
            mosivalid   <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rx_meta   <= RXD;
            rxs       <= rx_meta;
            rxs_d     <= rxs;
            word_done <= 1'b0;

            // Hand a completed word to the node only if it has taken the
            // previous one; otherwise the new word is lost.
            if (word_done) begin
                if (mosivalid == mosiack) begin
                    rxdata    <= rx_word;
                    mosivalid <= ~mosivalid;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (rx_state)
                RX_IDLE: begin
                    if (start_edge) begin
                        rx_state <= RX_START;
                        rx_timer <= HALF_LAST;
                        rx_tocnt <= '0;
                    end else if (rx_bytecnt != '0) begin
                        // A stalled partial word is dropped after TIMEOUT idle bit-times.
                        if (rx_tocnt == TO_LAST) begin
                            rx_bytecnt <= '0;
                            rx_tocnt   <= '0;
                        end else begin
                            rx_tocnt <= rx_tocnt + 1'b1;
                        end
                    end else begin
                        rx_tocnt <= '0;
                    end
                end
                RX_START: begin
                    if (rx_timer != '0) begin
                        rx_timer <= rx_timer - 1'b1;
                    end else if (rxs) begin
                        // Line went back high by mid start bit: treat as a glitch.
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state  <= RX_DATA;
                        rx_timer  <= BIT_LAST;
                        rx_bitcnt <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_timer != '0) begin
                        rx_timer <= rx_timer - 1'b1;
                    end else begin
                        rx_timer <= BIT_LAST;
                        if (rx_bitcnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                        rx_bitcnt <= rx_bitcnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_timer != '0) begin
                        rx_timer <= rx_timer - 1'b1;
                    end else if (rxs) begin
                        rx_state <= RX_IDLE;
                        if (rx_bytecnt == BYTE_LAST) begin
                            rx_bytecnt <= '0;
                            word_done  <= 1'b1;
                        end else begin
                            rx_bytecnt <= rx_bytecnt + 1'b1;
                        end
                    end else begin
                        framing_err <= 1'b1;
                        rx_bytecnt  <= '0;
                        rx_state    <= RX_WAITHI;
                    end
                end
                RX_WAITHI: begin
                    // Do not look for a new start edge until the line is back high.
                    if (rxs) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- transmit side ----------------
    logic [0:0]       tx_state;
    logic [TW-1:0]    tx_timer;
    logic [3:0]       tx_bitcnt;   // 0 start, 1..8 data, 9 stop
    logic [BW-1:0]    tx_bytecnt;
    logic [WIDTH-1:0] tx_word;
    logic [WIDTH-1:0] tx_word_shl;
    logic [7:0]       tx_bsh;

    logic tx_pending;
    logic tx_tick;
    logic tx_word_end;
    logic tx_load;
    logic tx_byte_next;
    logic tx_bit_next;

    assign tx_pending   = misovalid ^ misoack;
    assign tx_tick      = (tx_state == TX_SEND) && (tx_timer == '0);
    assign tx_word_end  = tx_tick && (tx_bitcnt == 4'd9) && (tx_bytecnt == BYTE_LAST);
    // A word pending at the end of the previous stop bit starts with no idle gap.
    assign tx_load      = tx_pending && ((tx_state == TX_IDLE) || tx_word_end);
    assign tx_byte_next = tx_tick && (tx_bitcnt == 4'd9) && (tx_bytecnt != BYTE_LAST);
    assign tx_bit_next  = tx_tick && (tx_bitcnt < 4'd8);
    assign tx_word_shl  = tx_word << 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            TXD        <= 1'b1;
            misoack    <= 1'b0;
            tx_state   <= TX_IDLE;
            tx_timer   <= '0;
            tx_bitcnt  <= '0;
            tx_bytecnt <= '0;
        end else if (tx_load) begin
            misoack    <= ~misoack;
            TXD        <= 1'b0;
            tx_state   <= TX_SEND;
            tx_timer   <= BIT_LAST;
            tx_bitcnt  <= '0;
            tx_bytecnt <= '0;
        end else if (tx_state == TX_SEND) begin
            if (!tx_tick) begin
                tx_timer <= tx_timer - 1'b1;
            end else begin
                tx_timer <= BIT_LAST;
                if (tx_bitcnt == 4'd9) begin
                    if (tx_bytecnt == BYTE_LAST) begin
                        tx_state <= TX_IDLE;
                        TXD      <= 1'b1;
                    end else begin
                        tx_bytecnt <= tx_bytecnt + 1'b1;
                        tx_bitcnt  <= '0;
                        TXD        <= 1'b0;
                    end
                end else begin
                    tx_bitcnt <= tx_bitcnt + 1'b1;
                    TXD       <= (tx_bitcnt == 4'd8) ? 1'b1 : tx_bsh[0];
                end
            end
        end
    end

    // Shift registers carry payload only; their contents are meaningless
    // until loaded, so they need no reset.
    always_ff @(posedge clk) begin
        if (rx_bit_smp) begin
            rx_sh <= {rxs, rx_sh[7:1]};
        end
        if (rx_byte_ok) begin
            rx_word <= (rx_word << 8) | WIDTH'(rx_sh);
        end
        if (tx_load) begin
            tx_word <= txdata;
            tx_bsh  <= txdata[WIDTH-1 -: 8];
        end else if (tx_byte_next) begin
            tx_word <= tx_word_shl;
            tx_bsh  <= tx_word_shl[WIDTH-1 -: 8];
        end else if (tx_bit_next) begin
            tx_bsh <= {1'b0, tx_bsh[7:1]};
        end
    end

endmodule

// File: tb/tb_ringuart.sv
// Bench for ringuart (WIDTH=16, CLKDIV=8, TIMEOUT=4). The node side loops
// mosiack back from mosivalid after three cycles unless held. Expected RX
// results come from a byte-level model of the framing rules; expected TX
// line levels come from a bit list built from each posted word.
module tb_ringuart;
    localparam int WIDTH   = 16;
    localparam int CLKDIV  = 8;
    localparam int TIMEOUT = 4;
    localparam int NB      = WIDTH / 8;
    localparam int TO_CYC  = TIMEOUT * CLKDIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              RXD = 1'b1;
    logic              TXD;
    logic [WIDTH-1:0]  rxdata;
    logic              mosivalid;
    logic              mosiack = 1'b0;
    logic [WIDTH-1:0]  txdata = '0;
    logic              misovalid = 1'b0;
    logic              misoack;
    logic              overrun;
    logic              framing_err;

    int n_tests = 0;
    int n_fail  = 0;

    // node-side and model state
    bit          hold = 1'b0;
    logic        frozen_ack = 1'b0;
    logic [2:0]  ack_pipe = '0;
    logic [15:0] m_rxdata = '0;
    logic [15:0] m_word = '0;
    bit          m_mv = 1'b0;
    bit          m_over = 1'b0;
    bit          m_ferr = 1'b0;
    int          m_nbytes = 0;
    int          m_edges = 0;
    int          mv_edges = 0;
    bit          tx_ack_m = 1'b0;

    logic        prev_mv = 1'b0;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_rx = '0;

    ringuart #(.WIDTH(WIDTH), .CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .RXD(RXD), .TXD(TXD), .rxdata(rxdata),
        .mosivalid(mosivalid), .mosiack(mosiack), .txdata(txdata),
        .misovalid(misovalid), .misoack(misoack), .overrun(overrun),
        .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // node: acknowledge three cycles after mosivalid moves, unless held
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ack_pipe = '0;
                mosiack  = 1'b0;
            end else begin
                ack_pipe = {ack_pipe[1:0], mosivalid};
                if (!hold) mosiack = ack_pipe[2];
            end
        end
    end

    // count mosivalid toggles; rxdata must not move while a word is pending
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mv_edges  = 0;
                prev_mv   = 1'b0;
                prev_pend = 1'b0;
            end else begin
                if (mosivalid != prev_mv) mv_edges++;
                if (prev_pend && (mosivalid != mosiack)) check_eq("rx_hold", rxdata, prev_rx);
                prev_mv   = mosivalid;
                prev_pend = (mosivalid != mosiack);
                prev_rx   = rxdata;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // byte-level model of what the receiver should do with one frame
    task automatic model_byte(input logic [7:0] b, input bit stop_ok, input int pre_gap);
        if (!stop_ok) begin
            m_ferr   = 1'b1;
            m_nbytes = 0;
            return;
        end
        if (m_nbytes != 0 && pre_gap > TO_CYC) m_nbytes = 0;
        m_word = {m_word[7:0], b};
        m_nbytes++;
        if (m_nbytes == NB) begin
            m_nbytes = 0;
            if (hold && (m_mv != frozen_ack)) begin
                m_over = 1'b1;
            end else begin
                m_rxdata = m_word;
                m_mv     = ~m_mv;
                m_edges++;
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        RXD = v;
        repeat (CLKDIV) tick();
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit stop_ok, input int pre_gap, input int glitch_len);
        RXD = 1'b1;
        repeat (pre_gap) tick();
        if (glitch_len > 0) begin
            RXD = 1'b0;
            repeat (glitch_len) tick();
            RXD = 1'b1;
            repeat (CLKDIV) tick();
        end
        model_byte(b, stop_ok, pre_gap);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        RXD = 1'b1;
    endtask

    task automatic check_rx(input string tag);
        repeat (20) tick();
        check_eq($sformatf("%s.rxdata", tag), rxdata, m_rxdata);
        check_eq($sformatf("%s.mosivalid", tag), mosivalid, m_mv);
        check_eq($sformatf("%s.edges", tag), mv_edges, m_edges);
        check_eq($sformatf("%s.overrun", tag), overrun, m_over);
        check_eq($sformatf("%s.framing", tag), framing_err, m_ferr);
    endtask

    // post one word (or two back-to-back) and follow TXD cycle by cycle
    task automatic tx_run(input logic [15:0] w1, input bit chain, input logic [15:0] w2);
        bit q[$];
        logic [15:0] words[2];
        logic [7:0] by;
        bit a1, a2;
        words[0] = w1;
        words[1] = w2;
        for (int w = 0; w < (chain ? 2 : 1); w++) begin
            for (int k = NB - 1; k >= 0; k--) begin
                by = words[w][8*k +: 8];
                repeat (CLKDIV) q.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (CLKDIV) q.push_back(by[i]);
                repeat (CLKDIV) q.push_back(1'b1);
            end
        end
        tick();
        txdata    = w1;
        misovalid = ~misovalid;
        a1 = ~tx_ack_m;
        a2 = tx_ack_m;
        tx_ack_m = a1;
        @(posedge clk);
        for (int n = 0; n < q.size(); n++) begin
            @(negedge clk);
            check_eq("txd", TXD, q[n]);
            check_eq("misoack", misoack, (chain && n >= NB * 10 * CLKDIV) ? a2 : a1);
            if (chain && n == 20) begin
                txdata    = w2;
                misovalid = ~misovalid;
            end
            if (!chain && n == 30) txdata = ~w1;
        end
        if (chain) tx_ack_m = a2;
        @(negedge clk);
        check_eq("txd_idle", TXD, 1'b1);
        check_eq("misoack_idle", misoack, tx_ack_m);
    endtask

    task automatic reset_model();
        m_rxdata = '0;
        m_mv     = 1'b0;
        m_over   = 1'b0;
        m_ferr   = 1'b0;
        m_nbytes = 0;
        m_edges  = 0;
        tx_ack_m = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq($sformatf("%s.txd", tag), TXD, 1'b1);
        check_eq($sformatf("%s.rxdata", tag), rxdata, 16'h0000);
        check_eq($sformatf("%s.mosivalid", tag), mosivalid, 1'b0);
        check_eq($sformatf("%s.misoack", tag), misoack, 1'b0);
        check_eq($sformatf("%s.overrun", tag), overrun, 1'b0);
        check_eq($sformatf("%s.framing", tag), framing_err, 1'b0);
    endtask

    initial begin
        logic [7:0]  b1, b2, b3;
        logic [15:0] w1, w2;
        int kind;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        repeat (4) tick();

        // basic inbound word
        rx_byte(8'h81, 1'b1, 4, 0);
        rx_byte(8'h23, 1'b1, 4, 0);
        check_rx("basic");
        check_eq("basic.value", rxdata, 16'h8123);

        // basic outbound word
        tx_run(16'hA55A, 1'b0, 16'h0000);

        // short low pulse between words, and one in front of a byte
        RXD = 1'b0;
        repeat (3) tick();
        RXD = 1'b1;
        check_rx("glitch_idle");
        rx_byte(8'h5A, 1'b1, 4, 0);
        rx_byte(8'hC3, 1'b1, 4, 3);
        check_rx("glitch_word");

        // bad stop bit, then a good word
        rx_byte(8'h81, 1'b0, 4, 0);
        rx_byte(8'h12, 1'b1, 2 * CLKDIV, 0);
        rx_byte(8'h34, 1'b1, 4, 0);
        check_rx("framing");
        check_eq("framing.value", rxdata, 16'h1234);
        check_eq("framing.flag", framing_err, 1'b1);

        // stalled partial word times out
        rx_byte(8'h81, 1'b1, 4, 0);
        rx_byte(8'h56, 1'b1, 40, 0);
        rx_byte(8'h78, 1'b1, 4, 0);
        check_rx("timeout");
        check_eq("timeout.value", rxdata, 16'h5678);

        // two outbound words back to back
        tx_run(16'($urandom), 1'b1, 16'($urandom));

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            kind = $urandom_range(0, 3);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            case (kind)
                0: begin
                    rx_byte(b1, 1'b1, $urandom_range(0, 12), 0);
                    rx_byte(b2, 1'b1, $urandom_range(0, 12), $urandom_range(0, 3));
                end
                1: begin
                    rx_byte(b1, 1'b1, $urandom_range(0, 12), 0);
                    rx_byte(b2, 1'b1, $urandom_range(40, 60), 0);
                    rx_byte(b3, 1'b1, $urandom_range(0, 12), 0);
                end
                2: begin
                    rx_byte(b1, 1'b0, $urandom_range(0, 12), 0);
                    rx_byte(b2, 1'b1, $urandom_range(CLKDIV, 2 * CLKDIV), 0);
                    rx_byte(b3, 1'b1, $urandom_range(0, 12), 0);
                end
                default: begin
                    w1 = 16'($urandom);
                    w2 = 16'($urandom);
                    fork
                        tx_run(w1, 1'($urandom_range(0, 1)), w2);
                        begin
                            rx_byte(b1, 1'b1, $urandom_range(0, 12), 0);
                            rx_byte(b2, 1'b1, $urandom_range(0, 12), 0);
                        end
                    join
                end
            endcase
            check_rx($sformatf("round%0d", r));
        end

        // reset in the middle of an outbound word
        tick();
        txdata    = 16'($urandom);
        misovalid = ~misovalid;
        repeat (50) tick();
        @(negedge clk);
        rst       = 1'b1;
        misovalid = 1'b0;
        #1;
        check_reset_state("midtx_rst");
        reset_model();
        repeat (3) tick();
        rst = 1'b0;
        repeat (30) tick();
        check_eq("post_rst.txd", TXD, 1'b1);
        check_eq("post_rst.misoack", misoack, 1'b0);

        // node stops acknowledging: second word is dropped
        hold       = 1'b1;
        frozen_ack = mosiack;
        rx_byte(8'h80, 1'b1, 4, 0);
        rx_byte(8'h01, 1'b1, 4, 0);
        rx_byte(8'h80, 1'b1, 4, 0);
        rx_byte(8'h02, 1'b1, 4, 0);
        check_rx("overrun");
        check_eq("overrun.value", rxdata, 16'h8001);
        check_eq("overrun.flag", overrun, 1'b1);
        hold = 1'b0;
        repeat (10) tick();
        rx_byte(8'($urandom), 1'b1, 4, 0);
        rx_byte(8'($urandom), 1'b1, 4, 0);
        check_rx("recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
